// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// op_sub exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, op_a, op_b, cin,
`ifdef SERIAL_ADD_SUB_EN
        output op_sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, cin,
`ifdef SERIAL_ADD_SUB_EN
        input  op_sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder time-shared over WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add the op_sub (A-B) mode.
module adder1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high unless flushed
// RUN   | one sum bit per cycle, cnt 0..WIDTH-1
// DONE  | result presented, waiting for out_ready
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    serial_add_ctrl_if.slave   bus,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the first WIDTH-1 sum bits; the MSB goes straight into sum_q.
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             add_s, add_co;

    adder1bit u_add (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        a_sh_d  = bus.op_a;
`ifdef SERIAL_ADD_SUB_EN
                        b_sh_d  = bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry_d = bus.op_sub ? 1'b1 : bus.cin;
`else
                        b_sh_d  = bus.op_b;
                        carry_d = bus.cin;
`endif
                    end
                end
                RUN: begin
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    sum_sh_d = sum_sh_q >> 1;
                    sum_sh_d[WIDTH-2] = add_s;
                    carry_d  = add_co;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        sum_d   = {add_s, sum_sh_q};
                        cout_d  = add_co;
                        ovf_d   = carry_q ^ add_co;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) & ~flush;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8); SERIAL_ADD_SUB_EN adds subtract cases.
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];

    serial_add_ctrl_if #(.WIDTH(W)) bus_if ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        res_t         r;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, c0};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = low[W-1] ^ full[W];
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.s = bus_if.sum;
        r.c = bus_if.cout;
        r.v = bus_if.ovf;
        return r;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sub);
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        bus_if.cin      = ci;
`ifdef SERIAL_ADD_SUB_EN
        bus_if.op_sub   = sub;
`endif
        #1;
        check_val("in_ready_idle", bus_if.in_ready, 1);
        exp_q.push_back(model(a, b, ci, sub));
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check_val("busy_accept", busy, 1);
    endtask

    task automatic finish_op(input int hold);
        int   n;
        res_t e;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            check_val("busy_run", busy, 1);
        end while (!bus_if.out_valid && n < 3 * W);
        check_val("latency", n, W);
        if (!bus_if.out_valid || exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_val("result", observed(), e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_result", observed(), e);
            check_val("hold_valid", bus_if.out_valid, 1);
            check_val("hold_in_ready", bus_if.in_ready, 0);
        end
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check_val("xfer_valid", bus_if.out_valid, 0);
        check_val("xfer_in_ready", bus_if.in_ready, 1);
        check_val("xfer_busy", busy, 0);
        check_val("xfer_keep", observed(), e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t saved;
        int   seen;
        bus_if.in_valid  = 1'b0;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.cin       = 1'b0;
        bus_if.out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus_if.op_sub    = 1'b0;
`endif
        #1;
        check_val("rst_sum", bus_if.sum, 0);
        check_val("rst_cout", bus_if.cout, 0);
        check_val("rst_ovf", bus_if.ovf, 0);
        check_val("rst_valid", bus_if.out_valid, 0);
        check_val("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", bus_if.in_ready, 1);

        start_op(8'h5A, 8'h33, 1'b0, 1'b0);
        finish_op(0);
        check_val("ex1_sum", bus_if.sum, 8'h8D);
        check_val("ex1_ovf", bus_if.ovf, 1);
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op(0);
        check_val("ex2_cout", bus_if.cout, 1);
        start_op(8'h7F, 8'h00, 1'b1, 1'b0);
        finish_op(5);
        check_val("ex3_sum", bus_if.sum, 8'h80);

        // asynchronous reset in the middle of a RUN
        start_op(8'h55, 8'h0F, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_val("mid_rst_sum", bus_if.sum, 0);
        check_val("mid_rst_cout", bus_if.cout, 0);
        check_val("mid_rst_ovf", bus_if.ovf, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_valid", bus_if.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h01, 8'h01, 1'b0, 1'b0);
        finish_op(0);
        check_val("post_rst_sum", bus_if.sum, 8'h02);

        // flush on the 4th RUN cycle
        saved = observed();
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        check_val("flush_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid) seen++;
        end
        check_val("flush_no_valid", seen, 0);
        check_val("flush_keep", observed(), saved);

        @(negedge clk);
        flush = 1'b1;
        bus_if.in_valid = 1'b1;
        #1;
        check_val("flush_in_ready", bus_if.in_ready, 0);
        @(posedge clk);
        #1;
        check_val("flush_no_accept", busy, 0);
        bus_if.in_valid = 1'b0;
        flush = 1'b0;

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            logic ci, sub;
            a   = W'($urandom_range(0, 255));
            b   = W'($urandom_range(0, 255));
            ci  = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
            sub = 1'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            start_op(a, b, ci, sub);
            finish_op(i % 3);
        end

`ifdef SERIAL_ADD_SUB_EN
        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        finish_op(0);
        check_val("sub1_sum", bus_if.sum, 8'hF0);
        check_val("sub1_cout", bus_if.cout, 0);
        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        finish_op(0);
        check_val("sub2_sum", bus_if.sum, 8'h7F);
        check_val("sub2_ovf", bus_if.ovf, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
